// File: rtl/core_seq_pkg.sv
// Shared definitions for the 8-bit core sequencer.
// State encodings and instruction field constants.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] REG0 = 2'b00;

  // Opcode in [7:6], rd in [5:4]
  function automatic logic is_rf_write(
    input logic [7:0] instr
  );
    return (instr[7:6] == OP_R) &&
           (instr[5:4] != REG0);
  endfunction

endpackage

// File: rtl/core_pc.sv
// Program counter for the core sequencer.
// Advances by one (wrapping) or loads a redirect target.
import core_seq_pkg::*;

module core_pc #(
  parameter int IMW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           load,
  input  logic [IMW-1:0] target,
  output logic [IMW-1:0] pc
);

  logic [IMW-1:0] pc_next;

  always_comb begin
    pc_next = pc;
    if (en) begin
      if (load) pc_next = target;
      else      pc_next = pc + IMW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= pc_next;
  end

endmodule

// File: rtl/core_seq.sv
// Multicycle fetch/decode/exec/writeback sequencer.
// Owns the IR and is the only source of register-file write strobes.
import core_seq_pkg::*;

module core_seq #(
  parameter int IW  = 8,
  parameter int IMW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  output logic           imem_req,
  output logic [IMW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [IW-1:0]  imem_data,
  output logic [IW-1:0]  ir,
  input  logic           dec_rf_we,
  input  logic           br_taken,
  input  logic [IMW-1:0] br_target,
  output logic           rf_we,
  output logic           alu_en,
  output logic           retire,
  output logic [IMW-1:0] pc,
  output logic           busy
);

  state_t         state;
  state_t         state_next;
  logic           redirect;
  logic [IMW-1:0] redirect_pc;
  logic           fetch_entry;
  logic           pc_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB: begin
        state_next = run ? S_FETCH : S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    pc_en    = 1'b0;
    busy     = (state != S_IDLE);
    unique case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC:  alu_en   = 1'b1;
      S_WB: begin
        rf_we  = dec_rf_we;
        retire = 1'b1;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_addr   = pc;
  assign fetch_entry = (state_next == S_FETCH) &&
                       (state != S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (state == S_FETCH && imem_valid) begin
      ir <= imem_data;
    end
  end

  // Branch decision captured at the end of EXEC, consumed in WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else if (state == S_EXEC) begin
      redirect    <= br_taken;
      redirect_pc <= br_target;
    end else if (fetch_entry) begin
      redirect    <= 1'b0;
    end
  end

  core_pc #(
    .IMW (IMW)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .en     (pc_en),
    .load   (redirect),
    .target (redirect_pc),
    .pc     (pc)
  );

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq.
// Inputs change 2ns after the rising edge; outputs are checked there.
import core_seq_pkg::*;

module tb_core_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic [7:0] ir;
  logic       dec_rf_we;
  logic       br_taken;
  logic [3:0] br_target;
  logic       rf_we;
  logic       alu_en;
  logic       retire;
  logic [3:0] pc;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  core_seq #(.IW(8), .IMW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .ir         (ir),
    .dec_rf_we  (dec_rf_we),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .rf_we      (rf_we),
    .alu_en     (alu_en),
    .retire     (retire),
    .pc         (pc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts in FETCH with zero-wait memory; ends in the next FETCH/IDLE
  task automatic run_instr(
    input logic [7:0] instr,
    input logic       br_exec,
    input logic       br_dec,
    input logic [3:0] tgt,
    input string      tag
  );
    imem_valid = 1'b1;
    imem_data  = instr;
    dec_rf_we  = is_rf_write(instr);
    tick();
    br_taken  = br_dec;
    br_target = tgt;
    tick();
    chk({tag, "_alu"}, 32'(alu_en), 32'd1);
    br_taken = br_exec;
    tick();
    br_taken = 1'b0;
    chk({tag, "_ret"}, 32'(retire), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 8'h00;
    dec_rf_we  = 1'b0;
    br_taken   = 1'b0;
    br_target  = 4'h0;
    #3;
    chk("rst_pc",   32'(pc),       32'd0);
    chk("rst_ir",   32'(ir),       32'd0);
    chk("rst_req",  32'(imem_req), 32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_rfwe", 32'(rf_we),    32'd0);
    chk("rst_ret",  32'(retire),   32'd0);
    #9;
    rst = 1'b0;

    // R-type rd=1, zero-wait
    run        = 1'b1;
    imem_valid = 1'b1;
    imem_data  = 8'h10;
    dec_rf_we  = is_rf_write(8'h10);
    tick();
    chk("t1_req",   32'(imem_req),  32'd1);
    chk("t1_addr",  32'(imem_addr), 32'd0);
    chk("t1_fwe",   32'(rf_we),     32'd0);
    tick();
    chk("t1_ir",    32'(ir),        32'h10);
    chk("t1_dreq",  32'(imem_req),  32'd0);
    chk("t1_dalu",  32'(alu_en),    32'd0);
    chk("t1_dwe",   32'(rf_we),     32'd0);
    chk("t1_dbusy", 32'(busy),      32'd1);
    tick();
    chk("t1_alu",   32'(alu_en),    32'd1);
    chk("t1_ewe",   32'(rf_we),     32'd0);
    chk("t1_eret",  32'(retire),    32'd0);
    tick();
    chk("t1_wwe",   32'(rf_we),     32'd1);
    chk("t1_ret",   32'(retire),    32'd1);
    chk("t1_wpc",   32'(pc),        32'd0);
    tick();
    chk("t1_pc",    32'(pc),        32'd1);
    chk("t1_ret0",  32'(retire),    32'd0);
    chk("t1_req2",  32'(imem_req),  32'd1);

    // rd=0 instruction: no write, still retires
    imem_data = 8'h00;
    dec_rf_we = is_rf_write(8'h00);
    tick();
    tick();
    tick();
    chk("t2_we",  32'(rf_we),  32'd0);
    chk("t2_ret", 32'(retire), 32'd1);
    tick();
    chk("t2_pc",  32'(pc),     32'd2);

    // Three wait states on the fetch
    imem_valid = 1'b0;
    imem_data  = 8'hAB;
    for (int i = 0; i < 3; i++) begin
      chk("t3_req",  32'(imem_req),  32'd1);
      chk("t3_addr", 32'(imem_addr), 32'd2);
      tick();
      chk("t3_irh",  32'(ir),        32'h00);
    end
    chk("t3_req4", 32'(imem_req), 32'd1);
    imem_valid = 1'b1;
    imem_data  = 8'h5C;
    tick();
    chk("t3_ir",   32'(ir),       32'h5C);
    imem_data = 8'hFF;
    tick();
    chk("t3_irx",  32'(ir),       32'h5C);
    tick();
    chk("t3_ret",  32'(retire),   32'd1);
    tick();
    chk("t3_pc",   32'(pc),       32'd3);

    // Branch to 15, wrap to 0, branch to 9, ignored DECODE branch
    run_instr(8'h20, 1'b1, 1'b0, 4'hF, "b15");
    chk("b15_pc",  32'(pc), 32'd15);
    run_instr(8'h30, 1'b0, 1'b0, 4'h0, "wrap");
    chk("wrap_pc", 32'(pc), 32'd0);
    run_instr(8'h40, 1'b1, 1'b0, 4'h9, "b9");
    chk("b9_pc",   32'(pc), 32'd9);
    run_instr(8'h10, 1'b0, 1'b1, 4'h2, "bdec");
    chk("bdec_pc", 32'(pc), 32'd10);

    // run dropped in EXEC: finish, then idle
    imem_data = 8'h10;
    dec_rf_we = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    chk("r0_we",   32'(rf_we),  32'd1);
    chk("r0_ret",  32'(retire), 32'd1);
    tick();
    chk("r0_busy", 32'(busy),   32'd0);
    chk("r0_pc",   32'(pc),     32'd11);
    tick();
    tick();
    chk("r0_req",  32'(imem_req), 32'd0);
    chk("r0_idwe", 32'(rf_we),    32'd0);
    run = 1'b1;
    tick();
    chk("r1_req",  32'(imem_req),  32'd1);
    chk("r1_addr", 32'(imem_addr), 32'd11);

    // Asynchronous reset in WB
    tick();
    tick();
    tick();
    chk("rw_we",   32'(rf_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rw_we0",  32'(rf_we),  32'd0);
    chk("rw_ret0", 32'(retire), 32'd0);
    chk("rw_pc",   32'(pc),     32'd0);
    chk("rw_busy", 32'(busy),   32'd0);
    chk("rw_ir",   32'(ir),     32'd0);
    #10;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multicycle sequencer for the 8-bit core.
- Fetches instructions from instruction memory over a req/valid handshake and holds them in an instruction register (IR) that feeds the decoder.
- Gates the decoder's register-file write enable into a single writeback cycle, then advances the PC.
- Sits between instruction memory, the decoder and the register file/ALU; it is the only source of register-file write strobes.

Parameters:
- IW, 8, instruction width in bits.
- IMW, 4, instruction-memory address width; PC range 0..2^IMW-1.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = execute instructions, 0 = finish current instruction then idle.
- imem_req  out  1  fetch request, held high until accepted.
- imem_addr  out  IMW  fetch address (= PC).
- imem_valid  in  1  instruction-memory data valid; completes the fetch.
- imem_data  in  IW  fetched instruction.
- ir  out  IW  instruction register, drives the decoder input.
- dec_rf_we  in  1  decoder's write-enable (R-type and rd != reg0).
- br_taken  in  1  execute-stage redirect request.
- br_target  in  IMW  redirect PC.
- rf_we  out  1  gated register-file write strobe.
- alu_en  out  1  high during the execute cycle.
- retire  out  1  one-cycle pulse per completed instruction.
- pc  out  IMW  current PC.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - state=IDLE, pc=0, ir=0.
  - imem_req=0, rf_we=0, alu_en=0, retire=0, busy=0.
- States: IDLE, FETCH, DECODE, EXEC, WB. Encoding goes in the package.
- IDLE:
  - run=1 -> FETCH on the next edge; otherwise stay.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_valid=1 in the same cycle: ir<=imem_data, go to DECODE.
  - imem_valid=0: stay; req stays high and addr stays stable.
  - Zero-wait memory gives 1 cycle in FETCH.
- DECODE:
  - One cycle. ir is stable and the decoder settles. No outputs asserted except busy.
- EXEC:
  - One cycle, alu_en=1.
  - br_taken and br_target are sampled at the end of this cycle into a redirect latch.
- WB:
  - One cycle, rf_we = dec_rf_we.
  - retire=1.
  - pc <= redirect ? br_target : pc+1. pc+1 wraps modulo 2^IMW (2^IMW-1 -> 0).
  - Next state is FETCH if run=1, else IDLE.
- Latency: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXEC, WB); retire pulses every 4th cycle.
- run=0 mid-instruction: the current instruction completes through WB, including its write and PC update, then the block goes to IDLE. run is only sampled in IDLE and WB.
- imem_valid outside FETCH is ignored; ir does not change.
- br_taken outside EXEC is ignored.
- The redirect latch is cleared on entry to FETCH.
- rf_we is never high outside WB, regardless of dec_rf_we.
- rst asserted in any state (e.g. mid-FETCH with req pending, or in WB): return to the reset state immediately; no write or retire in that cycle.
- busy = (state != IDLE).

Decomposition:
- Shared package/definitions include holds:
  - state encodings S_IDLE..S_WB (3 bits);
  - the existing OP_R and REG0 constants, reused by the bench's reference model.
- One natural sub-module: core_pc, holding the PC register with increment/wrap and load, enabled only in WB.
- The FSM and the IR stay in core_seq.

Test Plan:
- Reset then run=1, zero-wait memory, imem_data=8'h10 (R-type, rd=1) -> FETCH/DECODE/EXEC/WB sequence; rf_we=1 only in WB; retire at cycle 4; pc 0->1.
- Instruction with rd=0 (8'h00), dec_rf_we=0 -> rf_we stays 0 in WB; retire still pulses; pc increments.
- imem_valid delayed 3 cycles -> imem_req held high with imem_addr constant for 4 cycles; ir loads only in the valid cycle; total latency 7 cycles.
- pc=15 with IMW=4 and no branch -> next pc=0. br_taken=1 with br_target=4'h9 in EXEC -> pc=9 after WB; br_taken pulsed in DECODE instead -> ignored, pc=pc+1.
- run dropped during EXEC -> WB completes (write and retire), then IDLE with busy=0; imem_req stays 0 until run returns.
- rst asserted in WB while dec_rf_we=1 -> rf_we and retire are 0 in that cycle; pc=0, state IDLE immediately, without waiting for a clock edge.
